// File: rtl/univ_shift_ctrl.sv
// Command sequencer for a univ_shift register: accepts one command over valid/ready,
// drives the register control/data for the required cycles, then captures the result.
module univ_shift_ctrl #(
    parameter int n     = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [n-1:0]     cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [1:0]       sr_control,
    output logic [n-1:0]     sr_data_in,
    input  logic [n-1:0]     sr_data_out,
    output logic [n-1:0]     result,
    output logic             done,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, CAPTURE} state_t;
    typedef enum logic [1:0] {OP_HOLD, OP_SHL, OP_SHR, OP_LOAD} op_t;

    state_t           state_q, state_d;
    logic [1:0]       sr_control_q, sr_control_d;
    logic [n-1:0]     sr_data_in_q, sr_data_in_d;
    logic [n-1:0]     result_q, result_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sr_control_q <= '0;
            sr_data_in_q <= '0;
            result_q     <= '0;
            done_q       <= 1'b0;
            remaining_q  <= '0;
        end else begin
            state_q      <= state_d;
            sr_control_q <= sr_control_d;
            sr_data_in_q <= sr_data_in_d;
            result_q     <= result_d;
            done_q       <= done_d;
            remaining_q  <= remaining_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sr_control_d = sr_control_q;
        sr_data_in_d = sr_data_in_q;
        result_d     = result_q;
        done_d       = 1'b0;
        remaining_d  = remaining_q;
        case (state_q)
            IDLE: begin
                sr_control_d = '0;
                if (cmd_valid) begin
                    case (op_t'(cmd_op))
                        OP_LOAD: begin
                            sr_data_in_d = cmd_data;
                            sr_control_d = 2'd3;
                            remaining_d  = CNT_W'(1);
                            state_d      = RUN;
                        end
                        OP_SHL, OP_SHR: begin
                            if (cmd_count != '0) begin
                                sr_control_d = cmd_op;
                                remaining_d  = cmd_count;
                                state_d      = RUN;
                            end else begin
                                state_d = CAPTURE;
                            end
                        end
                        default: state_d = CAPTURE;
                    endcase
                end
            end
            RUN: begin
                // Control drops on the edge that consumes the last count, so the
                // register sees the op on exactly `count` edges.
                remaining_d = remaining_q - CNT_W'(1);
                if (remaining_q <= CNT_W'(1)) begin
                    remaining_d  = '0;
                    sr_control_d = '0;
                    state_d      = CAPTURE;
                end
            end
            CAPTURE: begin
                sr_control_d = '0;
                result_d     = sr_data_out;
                done_d       = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                sr_control_d = '0;
                state_d      = IDLE;
            end
        endcase
    end

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign sr_control = sr_control_q;
    assign sr_data_in = sr_data_in_q;
    assign result     = result_q;
    assign done       = done_q;

endmodule
